uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Shares the single UART transmitter between two requesters: the command-response byte (0xA5/0x5A from the command path) and a decimated heading telemetry stream.
- Sits between cmd_proc/TourCmd and UART_wrapper. It takes over the trmt/resp/tx_done connection so heading can be streamed over BLE during a tour without corrupting command acknowledgements.
- Responses always win arbitration. A telemetry frame is atomic and is never interleaved with a response.

Parameters:
- DECIM, 8, number of heading_rdy pulses per telemetry capture (1..255).
- TLM_HDR, 4'hC, upper nibble of the first telemetry byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset (synchronized copy from rst_synch)
- send_resp  input  1  single-cycle request to send resp_in
- resp_in  input  8  response byte, sampled when send_resp=1
- resp_sent  output  1  single-cycle pulse when the response byte has finished transmitting
- tlm_en  input  1  telemetry enable, level
- heading_rdy  input  1  single-cycle pulse, new heading valid
- heading  input  12  signed heading
- tx_data  output  8  byte to UART transmitter
- trmt  output  1  single-cycle start-transmit pulse to UART
- tx_done  input  1  single-cycle pulse from UART when the byte is finished
- drop_cnt  output  8  saturating count of overwritten telemetry snapshots
- busy  output  1  high while in any state other than IDLE

Behaviour:
- Reset values: tx_data=0, trmt=0, resp_sent=0, drop_cnt=0, busy=0; state=IDLE; all pending flags and the decimation counter are cleared.
- Response capture:
  - send_resp sets resp_pend and latches resp_in into resp_q, in any state.
  - A second send_resp while resp_pend=1 overwrites resp_q; the last value wins.
  - resp_pend clears on the cycle the arbiter launches the response byte.
- Telemetry capture:
  - When tlm_en=1, each heading_rdy increments dec_cnt.
  - When dec_cnt reaches DECIM-1 on a heading_rdy:
    - dec_cnt wraps to 0;
    - heading is latched into tlm_q;
    - tlm_pend is set.
  - If tlm_pend is already 1 at capture, tlm_q is overwritten and drop_cnt increments, saturating at 255.
  - When tlm_en=0: dec_cnt is held at 0, tlm_pend is cleared, and new captures are blocked. A frame already launched still completes.
- FSM states: IDLE, RESP, TLM_HI, TLM_LO.
  - IDLE, resp_pend=1 → RESP. Same cycle: trmt=1, tx_data=resp_q.
  - IDLE, resp_pend=0, tlm_pend=1 → TLM_HI. Same cycle: trmt=1, tx_data={TLM_HDR, tlm_q[11:8]}, and tlm_pend clears. tlm_q stays stable for the frame; a new capture goes to a shadow register plus pend (same overwrite/drop rule).
  - RESP, on tx_done → IDLE, with resp_sent=1 that cycle.
  - TLM_HI, on tx_done → TLM_LO. Same cycle: trmt=1, tx_data=tlm_q[7:0].
  - TLM_LO, on tx_done → IDLE.
- Arbitration occurs only in IDLE. A response requested during TLM_HI/TLM_LO waits until the frame ends, then launches on the first IDLE cycle.
- Latency:
  - trmt asserts the cycle after send_resp when idle; the registered request is decided in IDLE the next cycle.
  - Back-to-back: the next launch asserts trmt one cycle after the tx_done that returned to IDLE.
- trmt is strictly one cycle wide. tx_data holds its value from the trmt cycle until the next launch.
- send_resp and heading_rdy on the same cycle: both are captured, response is served first.
- tx_done in IDLE is ignored.
- Reset mid-frame: everything clears immediately. The UART may finish its byte; the resulting tx_done is ignored in IDLE.

Test Plan:
- Response only: reset, send_resp with resp_in=0xA5 → one trmt, tx_data=0xA5. tx_done 100 cycles later → resp_sent pulse, busy=0.
- Telemetry decimation: tlm_en=1, DECIM=8, heading=12'h3F2 on 8 heading_rdy pulses → frame bytes 0xC3 then 0xF2, trmt pulses exactly 2, no frame before the 8th pulse.
- Collision: heading_rdy completes a capture on the same cycle send_resp=1 with 0x5A → 0x5A sent first, then the telemetry frame. If send_resp arrives during TLM_HI, the response is sent after the TLM_LO tx_done.
- Overrun: DECIM=1, heading_rdy every cycle while tx_done is withheld 1000 cycles → drop_cnt saturates at 255, and the frame after release carries the latest heading.
- Disable mid-frame: tlm_en deasserted during TLM_HI → TLM_LO still sent, no further frames, dec_cnt=0.
- Async reset asserted in TLM_LO → all outputs 0 immediately. A later tx_done produces no trmt or resp_sent.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter between command responses and decimated heading telemetry.
// Responses always win arbitration; a two-byte telemetry frame is never split by a response.
module uart_tx_arb #(
    parameter int unsigned DECIM   = 8,
    parameter logic [3:0]  TLM_HDR = 4'hC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_resp,
    input  logic [7:0]  resp_in,
    output logic        resp_sent,
    input  logic        tlm_en,
    input  logic        heading_rdy,
    input  logic [11:0] heading,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESP   = 2'd1;
    localparam logic [1:0] ST_TLM_HI = 2'd2;
    localparam logic [1:0] ST_TLM_LO = 2'd3;
    localparam logic [7:0] DEC_LAST  = 8'(DECIM - 1);

    logic [1:0]  state_r;
    logic [1:0]  state_nx_s;
    logic        resp_pend_r;
    logic [7:0]  resp_q_r;
    logic [7:0]  dec_cnt_r;
    logic        tlm_pend_r;
    logic [11:0] tlm_snap_r;
    logic [11:0] tlm_frame_r;
    logic [7:0]  drop_cnt_r;
    logic [7:0]  tx_data_r;
    logic [7:0]  tx_data_nx_s;
    logic        trmt_r;
    logic        trmt_nx_s;
    logic        resp_sent_r;
    logic        resp_sent_nx_s;
    logic        busy_r;

    logic        capture_s;
    logic        resp_req_s;
    logic [7:0]  resp_byte_s;
    logic        launch_resp_s;
    logic        launch_tlm_s;

    // A send_resp arriving while idle is served directly so trmt follows it by one cycle.
    assign capture_s     = tlm_en & heading_rdy & (dec_cnt_r == DEC_LAST);
    assign resp_req_s    = resp_pend_r | send_resp;
    assign resp_byte_s   = send_resp ? resp_in : resp_q_r;
    assign launch_resp_s = (state_r == ST_IDLE) & resp_req_s;
    assign launch_tlm_s  = (state_r == ST_IDLE) & ~resp_req_s & tlm_pend_r & tlm_en;

    // Next-state and launch decode for the transmit sequencer.
    always_comb begin
        state_nx_s     = state_r;
        trmt_nx_s      = 1'b0;
        tx_data_nx_s   = tx_data_r;
        resp_sent_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (launch_resp_s) begin
                    state_nx_s   = ST_RESP;
                    trmt_nx_s    = 1'b1;
                    tx_data_nx_s = resp_byte_s;
                end else if (launch_tlm_s) begin
                    state_nx_s   = ST_TLM_HI;
                    trmt_nx_s    = 1'b1;
                    tx_data_nx_s = {TLM_HDR, tlm_snap_r[11:8]};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (tx_done) begin
                    state_nx_s     = ST_IDLE;
                    resp_sent_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_TLM_HI: begin
                if (tx_done) begin
                    state_nx_s   = ST_TLM_LO;
                    trmt_nx_s    = 1'b1;
                    tx_data_nx_s = tlm_frame_r[7:0];
                end else begin
                    state_nx_s = ST_TLM_HI;
                end
            end
            ST_TLM_LO: begin
                if (tx_done) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_TLM_LO;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered UART-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            trmt_r      <= 1'b0;
            tx_data_r   <= 8'h00;
            resp_sent_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            trmt_r      <= trmt_nx_s;
            tx_data_r   <= tx_data_nx_s;
            resp_sent_r <= resp_sent_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Pending response; the launch consumes any same-cycle request too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pend_r <= 1'b0;
            resp_q_r    <= 8'h00;
        end else if (launch_resp_s) begin
            resp_pend_r <= 1'b0;
        end else if (send_resp) begin
            resp_pend_r <= 1'b1;
            resp_q_r    <= resp_in;
        end else begin
            resp_pend_r <= resp_pend_r;
        end
    end

    // Heading decimation counter, held at zero while telemetry is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_r <= 8'h00;
        end else if (!tlm_en) begin
            dec_cnt_r <= 8'h00;
        end else if (heading_rdy) begin
            dec_cnt_r <= capture_s ? 8'h00 : dec_cnt_r + 8'h01;
        end else begin
            dec_cnt_r <= dec_cnt_r;
        end
    end

    // Snapshot staging: captures land in tlm_snap_r; tlm_frame_r stays frozen for the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlm_pend_r  <= 1'b0;
            tlm_snap_r  <= 12'h000;
            tlm_frame_r <= 12'h000;
        end else begin
            if (!tlm_en) begin
                tlm_pend_r <= 1'b0;
            end else if (capture_s) begin
                tlm_pend_r <= 1'b1;
            end else if (launch_tlm_s) begin
                tlm_pend_r <= 1'b0;
            end else begin
                tlm_pend_r <= tlm_pend_r;
            end
            if (capture_s) begin
                tlm_snap_r <= heading;
            end else begin
                tlm_snap_r <= tlm_snap_r;
            end
            if (launch_tlm_s) begin
                tlm_frame_r <= tlm_snap_r;
            end else begin
                tlm_frame_r <= tlm_frame_r;
            end
        end
    end

    // Overwriting an unsent snapshot counts as a drop; a snapshot being launched is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'h00;
        end else if (capture_s && tlm_pend_r && !launch_tlm_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign tx_data   = tx_data_r;
    assign trmt      = trmt_r;
    assign resp_sent = resp_sent_r;
    assign drop_cnt  = drop_cnt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: one instance with DECIM=8, one with DECIM=1 for overrun.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic        send_resp;
    logic [7:0]  resp_in;
    logic        resp_sent;
    logic        tlm_en;
    logic        heading_rdy;
    logic [11:0] heading;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [7:0]  drop_cnt;
    logic        busy;

    logic        send_resp1;
    logic [7:0]  resp_in1;
    logic        resp_sent1;
    logic        tlm_en1;
    logic        heading_rdy1;
    logic [11:0] heading1;
    logic [7:0]  tx_data1;
    logic        trmt1;
    logic        tx_done1;
    logic [7:0]  drop_cnt1;
    logic        busy1;

    int errors = 0;
    int checks = 0;
    int trmt_cnt = 0;
    int rec;

    uart_tx_arb #(.DECIM(8), .TLM_HDR(4'hC)) u_dut (
        .clk(clk), .rst_n(rst_n), .send_resp(send_resp), .resp_in(resp_in),
        .resp_sent(resp_sent), .tlm_en(tlm_en), .heading_rdy(heading_rdy),
        .heading(heading), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    uart_tx_arb #(.DECIM(1), .TLM_HDR(4'hC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .send_resp(send_resp1), .resp_in(resp_in1),
        .resp_sent(resp_sent1), .tlm_en(tlm_en1), .heading_rdy(heading_rdy1),
        .heading(heading1), .tx_data(tx_data1), .trmt(trmt1), .tx_done(tx_done1),
        .drop_cnt(drop_cnt1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count trmt pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (trmt === 1'b1) trmt_cnt <= trmt_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_hr();
        heading_rdy = 1'b1;
        step();
        heading_rdy = 1'b0;
        step();
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; send_resp = 1'b0; resp_in = 8'h00; tlm_en = 1'b0;
        heading_rdy = 1'b0; heading = 12'h000; tx_done = 1'b0;
        send_resp1 = 1'b0; resp_in1 = 8'h00; tlm_en1 = 1'b0;
        heading_rdy1 = 1'b0; heading1 = 12'h000; tx_done1 = 1'b0;
        repeat (3) step();
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_trmt", 32'(trmt), 32'h0);
        chk("rst_resp_sent", 32'(resp_sent), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();

        // Response only, tx_done 100 cycles after launch
        rec = trmt_cnt;
        send_resp = 1'b1; resp_in = 8'hA5;
        step();
        send_resp = 1'b0;
        chk("resp_trmt", 32'(trmt), 32'h1);
        chk("resp_tx_data", 32'(tx_data), 32'hA5);
        chk("resp_busy", 32'(busy), 32'h1);
        step();
        chk("resp_trmt_width", 32'(trmt), 32'h0);
        repeat (98) step();
        done_pulse();
        chk("resp_sent_pulse", 32'(resp_sent), 32'h1);
        chk("resp_busy_clear", 32'(busy), 32'h0);
        chk("resp_hold_data", 32'(tx_data), 32'hA5);
        step();
        chk("resp_sent_width", 32'(resp_sent), 32'h0);
        chk("resp_trmt_count", 32'(trmt_cnt - rec), 32'd1);

        // Telemetry decimation: frame only after the 8th heading_rdy
        tlm_en = 1'b1; heading = 12'h3F2;
        rec = trmt_cnt;
        repeat (7) pulse_hr();
        chk("tlm_no_early_frame", 32'(trmt_cnt - rec), 32'd0);
        chk("tlm_idle_before_8", 32'(busy), 32'h0);
        pulse_hr();
        chk("tlm_hi_trmt", 32'(trmt), 32'h1);
        chk("tlm_hi_byte", 32'(tx_data), 32'hC3);
        repeat (5) step();
        done_pulse();
        chk("tlm_lo_trmt", 32'(trmt), 32'h1);
        chk("tlm_lo_byte", 32'(tx_data), 32'hF2);
        repeat (5) step();
        done_pulse();
        chk("tlm_end_busy", 32'(busy), 32'h0);
        repeat (4) step();
        chk("tlm_trmt_count", 32'(trmt_cnt - rec), 32'd2);

        // Collision: capture and send_resp on the same cycle
        repeat (7) pulse_hr();
        heading_rdy = 1'b1; send_resp = 1'b1; resp_in = 8'h5A;
        step();
        heading_rdy = 1'b0; send_resp = 1'b0;
        chk("coll_resp_trmt", 32'(trmt), 32'h1);
        chk("coll_resp_byte", 32'(tx_data), 32'h5A);
        step();
        done_pulse();
        chk("coll_resp_sent", 32'(resp_sent), 32'h1);
        chk("coll_idle_gap", 32'(busy), 32'h0);
        step();
        chk("coll_tlm_trmt", 32'(trmt), 32'h1);
        chk("coll_tlm_hi", 32'(tx_data), 32'hC3);
        // Response requested mid-frame waits for TLM_LO to finish
        send_resp = 1'b1; resp_in = 8'h3C;
        step();
        send_resp = 1'b0;
        chk("mid_no_preempt", 32'(trmt), 32'h0);
        chk("mid_hi_busy", 32'(busy), 32'h1);
        done_pulse();
        chk("mid_lo_byte", 32'(tx_data), 32'hF2);
        done_pulse();
        chk("mid_lo_done_trmt", 32'(trmt), 32'h0);
        chk("mid_lo_done_idle", 32'(busy), 32'h0);
        step();
        chk("mid_resp_trmt", 32'(trmt), 32'h1);
        chk("mid_resp_byte", 32'(tx_data), 32'h3C);
        done_pulse();
        chk("mid_resp_sent", 32'(resp_sent), 32'h1);
        step();

        // Disable telemetry during TLM_HI
        heading = 12'h1B4;
        repeat (8) pulse_hr();
        chk("dis_hi_byte", 32'(tx_data), 32'hC1);
        tlm_en = 1'b0;
        step();
        done_pulse();
        chk("dis_lo_trmt", 32'(trmt), 32'h1);
        chk("dis_lo_byte", 32'(tx_data), 32'hB4);
        done_pulse();
        chk("dis_end_idle", 32'(busy), 32'h0);
        rec = trmt_cnt;
        repeat (10) pulse_hr();
        chk("dis_no_frames", 32'(trmt_cnt - rec), 32'd0);
        chk("dis_dec_cnt", 32'(u_dut.dec_cnt_r), 32'h0);

        // Async reset while in TLM_LO
        tlm_en = 1'b1; heading = 12'h2D7;
        repeat (8) pulse_hr();
        chk("rr_hi_byte", 32'(tx_data), 32'hC2);
        done_pulse();
        chk("rr_lo_trmt", 32'(trmt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_trmt", 32'(trmt), 32'h0);
        chk("rr_tx_data", 32'(tx_data), 32'h00);
        chk("rr_busy", 32'(busy), 32'h0);
        chk("rr_resp_sent", 32'(resp_sent), 32'h0);
        chk("rr_drop_cnt", 32'(drop_cnt), 32'h00);
        step();
        rst_n = 1'b1; tlm_en = 1'b0;
        rec = trmt_cnt;
        step();
        done_pulse();
        step();
        chk("rr_late_done_trmt", 32'(trmt_cnt - rec), 32'd0);
        chk("rr_late_done_sent", 32'(resp_sent), 32'h0);
        chk("rr_late_done_busy", 32'(busy), 32'h0);

        // Overrun on the DECIM=1 instance with tx_done withheld
        tlm_en1 = 1'b1; heading_rdy1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            heading1 = 12'(i);
            step();
        end
        heading1 = 12'h7E1;
        step();
        heading_rdy1 = 1'b0;
        step();
        chk("ovr_drop_sat", 32'(drop_cnt1), 32'hFF);
        chk("ovr_first_hi", 32'(tx_data1), 32'hC0);
        tx_done1 = 1'b1; step(); tx_done1 = 1'b0;
        chk("ovr_first_lo", 32'(tx_data1), 32'h00);
        tx_done1 = 1'b1; step(); tx_done1 = 1'b0;
        step();
        chk("ovr_next_trmt", 32'(trmt1), 32'h1);
        chk("ovr_latest_hi", 32'(tx_data1), 32'hC7);
        tx_done1 = 1'b1; step(); tx_done1 = 1'b0;
        chk("ovr_latest_lo", 32'(tx_data1), 32'hE1);
        chk("ovr_drop_hold", 32'(drop_cnt1), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
